psi_generator: RTL

Programmable pulse generator that produces the PSI waveform consumed by the frequency regulator: PSI is high for exactly `divisor` clock cycles, then low for `low_period` cycles, repeating while enabled. It closes the synchronizer loop: the regulator's `adjustedDiv` output drives this block's `divisor` input, and the generated PSI feeds back to the regulator. New divisor and low-period values take effect only at period boundaries, so the regulator never sees a truncated or stretched pulse.

---
 rtl/psi_pkg.sv | 18 +
 rtl/psi_generator_if.sv | 22 ++
 rtl/phase_counter.sv | 27 ++
 rtl/psi_generator.sv | 117 +++++++++++
 4 files changed

// File: rtl/psi_pkg.sv
// rtl/psi_pkg.sv - shared types, defaults and helpers for the PSI pulse generator
package psi_pkg;

    localparam int PSI_WIDTH = 8;
    localparam logic [PSI_WIDTH-1:0] RESET_DIV_DEFAULT = 8'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // A zero phase length is meaningless, so it runs as a single cycle.
    function automatic logic [PSI_WIDTH-1:0] clamp_nonzero(input logic [PSI_WIDTH-1:0] v);
        return (v == '0) ? PSI_WIDTH'(1) : v;
    endfunction

endpackage

// File: rtl/psi_generator_if.sv
// rtl/psi_generator_if.sv - control and status bundle between the regulator and the PSI generator
interface psi_generator_if #(parameter int WIDTH = 8);

    logic             en;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] low_period;
    logic             PSI;
    logic             period_done;
    logic [WIDTH-1:0] div_active;
    logic             busy;

    modport master (
        output en, divisor, low_period,
        input  PSI, period_done, div_active, busy
    );

    modport slave (
        input  en, divisor, low_period,
        output PSI, period_done, div_active, busy
    );

endinterface

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - loadable down-counter timing each PSI phase; tc flags the last cycle
module phase_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/psi_generator.sv
// rtl/psi_generator.sv - PSI pulse generator: divisor-cycle high, low_period-cycle low, repeating
// Divisor and low period are latched only at period boundaries so pulses are never truncated.
module psi_generator
    import psi_pkg::*;
#(
    parameter int                   WIDTH     = PSI_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_DIV = RESET_DIV_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    psi_generator_if.slave  bus
);

    state_t           state;
    logic             psi_q;
    logic             period_done_q;
    logic             busy_q;
    logic [WIDTH-1:0] div_active_q;
    logic [WIDTH-1:0] low_active;

    logic [WIDTH-1:0] div_eff;
    logic [WIDTH-1:0] low_eff;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_tc;

    assign div_eff = clamp_nonzero(bus.divisor);
    assign low_eff = clamp_nonzero(bus.low_period);

    // Counter is reloaded on every phase entry; otherwise it counts down inside a phase.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = div_eff - WIDTH'(1);
        cnt_dec      = 1'b0;
        case (state)
            IDLE: cnt_load = bus.en;
            HIGH: begin
                if (cnt_tc) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = low_active - WIDTH'(1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            LOW: begin
                if (cnt_tc) cnt_load = bus.en;
                else        cnt_dec  = 1'b1;
            end
            default: ;
        endcase
    end

    phase_counter #(.WIDTH(WIDTH)) u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            psi_q         <= 1'b0;
            period_done_q <= 1'b0;
            busy_q        <= 1'b0;
            div_active_q  <= RESET_DIV;
            low_active    <= WIDTH'(1);
        end else begin
            period_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state        <= HIGH;
                        psi_q        <= 1'b1;
                        busy_q       <= 1'b1;
                        div_active_q <= div_eff;
                        low_active   <= low_eff;
                    end
                end
                HIGH: begin
                    if (cnt_tc) begin
                        state <= LOW;
                        psi_q <= 1'b0;
                    end
                end
                LOW: begin
                    if (cnt_tc) begin
                        period_done_q <= 1'b1;
                        if (bus.en) begin
                            state        <= HIGH;
                            psi_q        <= 1'b1;
                            div_active_q <= div_eff;
                            low_active   <= low_eff;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    psi_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PSI         = psi_q;
    assign bus.period_done = period_done_q;
    assign bus.busy        = busy_q;
    assign bus.div_active  = div_active_q;

endmodule
